// File: rtl/mem_pkg.sv
// Shared widths, FSM state encoding and counter width for the data memory
// and the direct-mapped cache that sits in front of it.
package mem_pkg;

   localparam int ADDR_W_DEF = 6;
   localparam int DATA_W_DEF = 32;
   localparam int CNT_W      = 4;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE = 2'b00;
   localparam state_t ST_BUSY = 2'b01;
   localparam state_t ST_DONE = 2'b10;

endpackage

// File: rtl/data_memory_block_if.sv
// Cache <-> main-memory block bus: level request, block address/data and
// the BUSYWAIT stall handshake.
interface data_memory_block_if
   import mem_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
);

   logic              READ;
   logic              WRITE;
   logic [ADDR_W-1:0] ADDRESS;
   logic [DATA_W-1:0] WRITEDATA;
   logic [DATA_W-1:0] READDATA;
   logic              BUSYWAIT;

   modport master (output READ, WRITE, ADDRESS, WRITEDATA, input READDATA, BUSYWAIT);
   modport slave  (input READ, WRITE, ADDRESS, WRITEDATA, output READDATA, BUSYWAIT);

endinterface

// File: rtl/mem_block_array.sv
// Synchronous single-port block array with a registered read port.
module mem_block_array
   import mem_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk_i,
   input  logic              wr_en_i,
   input  logic              rd_en_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [2**ADDR_W];
   logic [DATA_W-1:0] rdata_q;

   // NOTE: storage and its read register carry no reset, so contents survive
   // a system reset and the array maps onto plain RAM macros.
   always_ff @(posedge clk_i) begin
      if (wr_en_i) mem_q[addr_i] <= wdata_i;
      if (rd_en_i) rdata_q <= mem_q[addr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/data_memory_block.sv
// Main data memory behind the data cache: fixed-latency block read/write
// with a level-sensitive BUSYWAIT stall.
module data_memory_block
   import mem_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int LATENCY = 5
) (
   input logic                CLOCK,
   input logic                RESET,
   data_memory_block_if.slave bus
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LATENCY - 1);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] lat_addr_q, lat_addr_d;
   logic [DATA_W-1:0] lat_data_q, lat_data_d;
   logic              lat_wr_q, lat_wr_d;
   logic              rd_seen_q, rd_seen_d;

   logic              req;
   logic              acc_en;
   logic              acc_wr;
   logic [ADDR_W-1:0] acc_addr;
   logic [DATA_W-1:0] acc_data;
   logic [DATA_W-1:0] arr_rdata;

   assign req = bus.READ | bus.WRITE;

   // NOTE: every signal assigned here gets a default first so no latch is inferred.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      lat_addr_d = lat_addr_q;
      lat_data_d = lat_data_q;
      lat_wr_d   = lat_wr_q;
      acc_en     = 1'b0;
      acc_wr     = lat_wr_q;
      acc_addr   = lat_addr_q;
      acc_data   = lat_data_q;
      case (state_q)
         ST_IDLE: begin
            if (req) begin
               lat_addr_d = bus.ADDRESS;
               lat_data_d = bus.WRITEDATA;
               lat_wr_d   = bus.WRITE;
               cnt_d      = CNT_W'(1);
               if (LATENCY == 1) begin
                  // Single-cycle build performs the access at the capture edge.
                  acc_en   = 1'b1;
                  acc_wr   = bus.WRITE;
                  acc_addr = bus.ADDRESS;
                  acc_data = bus.WRITEDATA;
                  state_d  = ST_DONE;
               end else begin
                  state_d  = ST_BUSY;
               end
            end
         end
         ST_BUSY: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_CNT) begin
               acc_en  = 1'b1;
               state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   assign rd_seen_d = rd_seen_q | (acc_en & ~acc_wr);

   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         lat_addr_q <= '0;
         lat_data_q <= '0;
         lat_wr_q   <= 1'b0;
         rd_seen_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         lat_addr_q <= lat_addr_d;
         lat_data_q <= lat_data_d;
         lat_wr_q   <= lat_wr_d;
         rd_seen_q  <= rd_seen_d;
      end
   end

   mem_block_array #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_array (
      .clk_i   (CLOCK),
      .wr_en_i (acc_en & acc_wr),
      .rd_en_i (acc_en & ~acc_wr),
      .addr_i  (acc_addr),
      .wdata_i (acc_data),
      .rdata_o (arr_rdata)
   );

   // The array's read register has no reset; READDATA reads zero until the
   // first read after reset lands.
   assign bus.READDATA = rd_seen_q ? arr_rdata : '0;
   assign bus.BUSYWAIT = ~RESET & (((state_q == ST_IDLE) & req) | (state_q == ST_BUSY));

endmodule

// File: tb/tb_data_memory_block.sv
// Directed bench for data_memory_block: LATENCY=5 and LATENCY=1 builds checked
// every cycle against a transaction-level model plus literal expectations.
module tb_data_memory_block;

   logic CLOCK = 1'b0;
   logic RESET = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   always #5 CLOCK = ~CLOCK;
   always @(posedge CLOCK) cyc++;

   data_memory_block_if #(.ADDR_W(6), .DATA_W(32)) bus5 ();
   data_memory_block_if #(.ADDR_W(6), .DATA_W(32)) bus1 ();

   data_memory_block #(.ADDR_W(6), .DATA_W(32), .LATENCY(5)) dut5 (
      .CLOCK (CLOCK),
      .RESET (RESET),
      .bus   (bus5.slave)
   );

   data_memory_block #(.ADDR_W(6), .DATA_W(32), .LATENCY(1)) dut1 (
      .CLOCK (CLOCK),
      .RESET (RESET),
      .bus   (bus1.slave)
   );

   logic        read_s  [2];
   logic        write_s [2];
   logic [5:0]  addr_s  [2];
   logic [31:0] wdata_s [2];
   logic        busy_s  [2];
   logic [31:0] rdata_s [2];

   assign read_s[0]  = bus5.READ;      assign read_s[1]  = bus1.READ;
   assign write_s[0] = bus5.WRITE;     assign write_s[1] = bus1.WRITE;
   assign addr_s[0]  = bus5.ADDRESS;   assign addr_s[1]  = bus1.ADDRESS;
   assign wdata_s[0] = bus5.WRITEDATA; assign wdata_s[1] = bus1.WRITEDATA;
   assign busy_s[0]  = bus5.BUSYWAIT;  assign busy_s[1]  = bus1.BUSYWAIT;
   assign rdata_s[0] = bus5.READDATA;  assign rdata_s[1] = bus1.READDATA;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Transaction-level model: a request seen while idle keeps BUSYWAIT high for
   // LATENCY cycles (request cycle included), then one low cycle in which the
   // access takes effect; reset abandons the access and zeroes READDATA.
   int          lat_of   [2] = '{5, 1};
   bit          m_active [2];
   int          m_t      [2];
   bit          m_wr     [2];
   logic [5:0]  m_addr   [2];
   logic [31:0] m_data   [2];
   logic [31:0] m_mem    [2][64];
   bit          m_known  [2][64];
   logic [31:0] m_rd     [2];
   bit          m_rd_ok  [2];

   always @(negedge CLOCK) begin
      for (int k = 0; k < 2; k++) begin
         logic exp_busy;
         if (RESET) begin
            m_active[k] = 1'b0;
            m_t[k]      = 0;
            m_rd[k]     = '0;
            m_rd_ok[k]  = 1'b1;
            exp_busy    = 1'b0;
         end else begin
            if (m_active[k]) m_t[k]++;
            else if (read_s[k] | write_s[k]) begin
               m_active[k] = 1'b1;
               m_t[k]      = 1;
               m_wr[k]     = write_s[k];
               m_addr[k]   = addr_s[k];
               m_data[k]   = wdata_s[k];
            end
            exp_busy = m_active[k];
            if (m_active[k] && m_t[k] == lat_of[k] + 1) begin
               exp_busy    = 1'b0;
               m_active[k] = 1'b0;
               if (m_wr[k]) begin
                  m_mem[k][m_addr[k]]   = m_data[k];
                  m_known[k][m_addr[k]] = 1'b1;
               end else begin
                  m_rd[k]    = m_mem[k][m_addr[k]];
                  m_rd_ok[k] = m_known[k][m_addr[k]];
               end
            end
         end
         check($sformatf("busywait[L=%0d]", lat_of[k]), {31'b0, busy_s[k]}, {31'b0, exp_busy});
         if (m_rd_ok[k]) check($sformatf("readdata[L=%0d]", lat_of[k]), rdata_s[k], m_rd[k]);
      end
   end

   task automatic set_req(input int k, input logic r, input logic w,
                          input logic [5:0] a, input logic [31:0] d);
      if (k == 0) begin
         bus5.READ = r; bus5.WRITE = w; bus5.ADDRESS = a; bus5.WRITEDATA = d;
      end else begin
         bus1.READ = r; bus1.WRITE = w; bus1.ADDRESS = a; bus1.WRITEDATA = d;
      end
   endtask

   // Starts at posedge+1, holds the request until the low BUSYWAIT cycle,
   // drops it at the following posedge+1.
   task automatic access(input int k, input logic r, input logic w, input logic [5:0] a,
                         input logic [31:0] d, output int nb, output logic [31:0] rdv);
      bit found = 1'b0;
      nb  = 0;
      rdv = '0;
      set_req(k, r, w, a, d);
      for (int i = 0; i < 40; i++) begin
         @(negedge CLOCK);
         if (busy_s[k]) nb++;
         else begin
            rdv   = rdata_s[k];
            found = 1'b1;
            break;
         end
      end
      check("access_completes", {31'b0, found}, 32'd1);
      @(posedge CLOCK); #1;
      set_req(k, 1'b0, 1'b0, 6'h00, 32'h0);
   endtask

   initial begin
      int          nb, c0;
      logic [31:0] rdv;
      bit          found;
      set_req(0, 1'b0, 1'b0, 6'h00, 32'h0);
      set_req(1, 1'b0, 1'b0, 6'h00, 32'h0);
      repeat (3) @(negedge CLOCK);
      check("busy_in_reset", {31'b0, busy_s[0]}, 32'd0);
      @(posedge CLOCK); #1;
      RESET = 1'b0;
      @(negedge CLOCK);
      check("readdata_after_reset", rdata_s[0], 32'h0);
      @(posedge CLOCK); #1;

      // Write then read back 0x2A.
      access(0, 1'b0, 1'b1, 6'h2A, 32'hDEADBEEF, nb, rdv);
      check("write_busy_cycles", nb, 5);
      access(0, 1'b1, 1'b0, 6'h2A, 32'h0, nb, rdv);
      check("read_busy_cycles", nb, 5);
      check("read_2A", rdv, 32'hDEADBEEF);

      // READ and WRITE together: write wins, READDATA untouched.
      access(0, 1'b1, 1'b1, 6'h05, 32'h12345678, nb, rdv);
      check("dual_keeps_readdata", rdv, 32'hDEADBEEF);
      access(0, 1'b1, 1'b0, 6'h05, 32'h0, nb, rdv);
      check("read_05", rdv, 32'h12345678);

      // Address change mid-access ignored; held READ restarts after DONE.
      access(0, 1'b0, 1'b1, 6'h10, 32'h10101010, nb, rdv);
      access(0, 1'b0, 1'b1, 6'h11, 32'h11111111, nb, rdv);
      set_req(0, 1'b1, 1'b0, 6'h10, 32'h0);
      repeat (2) @(posedge CLOCK);
      #1 bus5.ADDRESS = 6'h11;
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge CLOCK);
         if (!busy_s[0]) begin rdv = rdata_s[0]; found = 1'b1; break; end
      end
      check("toggle_done_seen", {31'b0, found}, 32'd1);
      check("read_latched_addr", rdv, 32'h10101010);
      @(negedge CLOCK);
      check("busy_again_after_done", {31'b0, busy_s[0]}, 32'd1);
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge CLOCK);
         if (!busy_s[0]) begin rdv = rdata_s[0]; found = 1'b1; break; end
      end
      check("second_done_seen", {31'b0, found}, 32'd1);
      check("read_11", rdv, 32'h11111111);
      @(posedge CLOCK); #1;
      set_req(0, 1'b0, 1'b0, 6'h00, 32'h0);

      // Reset during an in-flight write discards it.
      access(0, 1'b0, 1'b1, 6'h3F, 32'h3F3F3F3F, nb, rdv);
      set_req(0, 1'b0, 1'b1, 6'h3F, 32'hCAFEF00D);
      repeat (3) @(posedge CLOCK);
      #1 RESET = 1'b1;
      set_req(0, 1'b0, 1'b0, 6'h00, 32'h0);
      @(negedge CLOCK);
      check("busy_dropped_by_reset", {31'b0, busy_s[0]}, 32'd0);
      @(posedge CLOCK); #1;
      RESET = 1'b0;
      access(0, 1'b1, 1'b0, 6'h3F, 32'h0, nb, rdv);
      check("read_3F_survives", rdv, 32'h3F3F3F3F);

      // Dirty eviction followed by fill.
      access(0, 1'b0, 1'b1, 6'h29, 32'h0F0F0F0F, nb, rdv);
      c0 = cyc;
      access(0, 1'b0, 1'b1, 6'h09, 32'hAAAA5555, nb, rdv);
      access(0, 1'b1, 1'b0, 6'h29, 32'h0, nb, rdv);
      check("evict_fill_cycles", cyc - c0, 12);
      check("fill_29", rdv, 32'h0F0F0F0F);
      access(0, 1'b1, 1'b0, 6'h09, 32'h0, nb, rdv);
      check("read_09", rdv, 32'hAAAA5555);

      // LATENCY=1 build.
      access(1, 1'b0, 1'b1, 6'h00, 32'h00C0FFEE, nb, rdv);
      check("l1_write_busy_cycles", nb, 1);
      access(1, 1'b1, 1'b0, 6'h00, 32'h0, nb, rdv);
      check("l1_read_busy_cycles", nb, 1);
      check("l1_read_00", rdv, 32'h00C0FFEE);

      repeat (2) @(negedge CLOCK);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

endmodule
